// File: rtl/receiver_uart.sv
// receiver_uart: 1-start / 8-data (LSB first) / 1-stop UART receiver, no parity.
// CLKS_PER_BIT sets the baud rate; a value of 1 matches a transmitter that
// shifts one bit per clk.
//
// Optional build macro UART_RX_HOLD_EN:
//   defined   - rx_valid is a level held until rx_ack; overrun is a sticky flag
//   undefined - rx_valid is a 1-cycle pulse, rx_ack is ignored, overrun is 0
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to go low (start edge)
// START     | counting to mid start bit to confirm it is not a glitch
// DATA      | sampling the 8 data bits, one every CLKS_PER_BIT clocks
// STOP      | sampling the stop bit; good frame loads rx_data
// WAIT_HIGH | stop bit was 0 (framing error/break); wait for line high
module receiver_uart #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun
);

   localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
   localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             sync_a, rx_s;
   logic             load, ferr;

   // Two-flop synchronizer; resets to the idle line level so reset never
   // looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_a <= rx_in;
         rx_s   <= sync_a;
      end
   end

   // State, bit counters and shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
      end
   end

   // Next-state logic; STOP returns straight to IDLE so a start bit that
   // immediately follows the stop bit is still caught.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      load      = 1'b0;
      ferr      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               if (HALF_BIT == 0) begin
                  state_d   = DATA;
                  cnt_d     = '0;
                  bit_idx_d = '0;
               end else begin
                  state_d = START;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!rx_s) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d              = '0;
               shreg_d[bit_idx_q] = rx_s;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  load    = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr    = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output registers: data, valid and the frame-error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= ferr;
         if (load) begin
            rx_data <= shreg_q;
         end
`ifdef UART_RX_HOLD_EN
         rx_valid <= load | (rx_valid & ~rx_ack);
`else
         rx_valid <= load;
`endif
      end
   end

`ifdef UART_RX_HOLD_EN
   // Sticky overrun: a new byte landed while the previous one was unacked.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun <= 1'b0;
      end else if (load && rx_valid && !rx_ack) begin
         overrun <= 1'b1;
      end
   end
`else
   logic unused_ack;
   assign unused_ack = rx_ack;
   assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_receiver_uart.sv
// Bench for receiver_uart: two instances (1 and 16 clocks per bit), a
// scoreboard of expected bytes / frame errors with their arrival cycle, and a
// negedge monitor that pops and compares whenever a DUT flags an output.
module tb_receiver_uart;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx1, rx16, ack;
   logic [7:0] d1, d16;
   logic       v1, v16, fe1, fe16, ov1, ov16;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b1;
   exp_t q1[$];
   exp_t q16[$];
   int   f1[$];
   int   f16[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   receiver_uart #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .rx_in(rx1), .rx_ack(ack),
      .rx_data(d1), .rx_valid(v1), .frame_err(fe1), .overrun(ov1)
   );

   receiver_uart #(.CLKS_PER_BIT(16)) dut16 (
      .clk(clk), .rst(rst), .rx_in(rx16), .rx_ack(ack),
      .rx_data(d16), .rx_valid(v16), .frame_err(fe16), .overrun(ov16)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected assertion at cycle %0d", name, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one frame and record what the DUT must report and when.
   // First low sample reaches the FSM 3 edges after the start bit is driven;
   // the stop sample is HALF_BIT + 9 bit times later.
   task automatic send_frame(input bit wide, input logic [7:0] d, input logic stop_b,
                             input bit push);
      int         cpb;
      logic [9:0] bits;
      exp_t       e;
      cpb    = wide ? 16 : 1;
      bits   = {stop_b, d, 1'b0};
      e.data = d;
      e.cyc  = cyc + 3 + (wide ? 7 : 0) + 9 * cpb;
      if (push) begin
         if (stop_b) begin
            if (wide) q16.push_back(e); else q1.push_back(e);
         end else begin
            if (wide) f16.push_back(e.cyc); else f1.push_back(e.cyc);
         end
      end
      for (int i = 0; i < 10; i++) begin
         if (wide) rx16 = bits[i]; else rx1 = bits[i];
         repeat (cpb) tick();
      end
   endtask

   task automatic check_reset_outputs();
      chk("reset dut1 rx_data", d1, 8'h00);
      chk("reset dut1 rx_valid", v1, 1'b0);
      chk("reset dut1 frame_err", fe1, 1'b0);
      chk("reset dut1 overrun", ov1, 1'b0);
      chk("reset dut16 rx_data", d16, 8'h00);
      chk("reset dut16 rx_valid", v16, 1'b0);
      chk("reset dut16 frame_err", fe16, 1'b0);
      chk("reset dut16 overrun", ov16, 1'b0);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && rst) begin
         if (v1) begin
            if (q1.size() == 0) unexpected("dut1 rx_valid");
            else begin
               e = q1.pop_front();
               chk("dut1 rx_data", d1, e.data);
               chk("dut1 rx_valid cycle", cyc, e.cyc);
            end
         end
         if (fe1) begin
            if (f1.size() == 0) unexpected("dut1 frame_err");
            else chk("dut1 frame_err cycle", cyc, f1.pop_front());
         end
         if (v16) begin
            if (q16.size() == 0) unexpected("dut16 rx_valid");
            else begin
               e = q16.pop_front();
               chk("dut16 rx_data", d16, e.data);
               chk("dut16 rx_valid cycle", cyc, e.cyc);
            end
         end
         if (fe16) begin
            if (f16.size() == 0) unexpected("dut16 frame_err");
            else chk("dut16 frame_err cycle", cyc, f16.pop_front());
         end
      end
   end

   initial begin
      logic [7:0] part;
      rst  = 1'b0;
      rx1  = 1'b1;
      rx16 = 1'b1;
      ack  = 1'b1;
      repeat (3) tick();
      check_reset_outputs();
      rst = 1'b1;
      repeat (4) tick();

      // single frame 0x4A
      send_frame(1'b0, 8'h4A, 1'b1, 1'b1);
      repeat (5) tick();

      // back-to-back frames, no idle gap
      send_frame(1'b0, 8'h55, 1'b1, 1'b1);
      send_frame(1'b0, 8'hAA, 1'b1, 1'b1);
      send_frame(1'b0, 8'hFF, 1'b1, 1'b1);
      send_frame(1'b0, 8'h00, 1'b1, 1'b1);
      repeat (5) tick();

      // 16 clocks per bit: 0xC3 then a 5-clock low glitch
      send_frame(1'b1, 8'hC3, 1'b1, 1'b1);
      repeat (32) tick();
      rx16 = 1'b0;
      repeat (5) tick();
      rx16 = 1'b1;
      repeat (60) tick();

      // bad stop bit, 20-clock break, then a good frame
      send_frame(1'b0, 8'h81, 1'b0, 1'b1);
      rx1 = 1'b0;
      repeat (20) tick();
      rx1 = 1'b1;
      repeat (2) tick();
      send_frame(1'b0, 8'h12, 1'b1, 1'b1);
      repeat (5) tick();

      // reset in the middle of the data bits of 0x99
      part = 8'h99;
      rx1  = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         rx1 = part[i];
         tick();
      end
      rst = 1'b0;
      #1;
      check_reset_outputs();
      rx1 = 1'b1;
      repeat (3) tick();
      check_reset_outputs();
      rst = 1'b1;
      repeat (3) tick();
      send_frame(1'b0, 8'h3C, 1'b1, 1'b1);
      repeat (5) tick();
      chk("dut1 rx_data after reset frame", d1, 8'h3C);

`ifdef UART_RX_HOLD_EN
      // unacked byte followed by another: held valid, overwrite, overrun
      mon_en = 1'b0;
      ack    = 1'b0;
      send_frame(1'b0, 8'h11, 1'b1, 1'b0);
      repeat (4) tick();
      chk("hold rx_valid held", v1, 1'b1);
      chk("hold rx_data first", d1, 8'h11);
      chk("hold overrun clear", ov1, 1'b0);
      send_frame(1'b0, 8'h22, 1'b1, 1'b0);
      repeat (4) tick();
      chk("hold rx_valid after second", v1, 1'b1);
      chk("hold rx_data overwritten", d1, 8'h22);
      chk("hold overrun set", ov1, 1'b1);
      ack = 1'b1;
      tick();
      chk("hold rx_valid cleared by ack", v1, 1'b0);
      chk("hold overrun sticky", ov1, 1'b1);
      repeat (2) tick();
      mon_en = 1'b1;
`else
      // rx_ack is ignored: both bytes still pulse, overrun stays 0
      ack = 1'b0;
      send_frame(1'b0, 8'h11, 1'b1, 1'b1);
      send_frame(1'b0, 8'h22, 1'b1, 1'b1);
      repeat (5) tick();
      chk("dut1 overrun tied low", ov1, 1'b0);
      ack = 1'b1;
      repeat (2) tick();
`endif

      repeat (20) tick();
      chk("dut1 bytes still pending", q1.size(), 0);
      chk("dut1 frame errors still pending", f1.size(), 0);
      chk("dut16 bytes still pending", q16.size(), 0);
      chk("dut16 frame errors still pending", f16.size(), 0);
      chk("dut16 overrun", ov16, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
